// File: rtl/trng_pkg.sv
// ============================================================================
// Module   : trng_pkg
// Purpose  : Shared state encoding, counter-width helpers and rotate helper
//            for the trng_pool random-number pool.
// Revision : 1.0
// ============================================================================
`default_nettype none

package trng_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAULT   = 2'd2
    } trng_state_e;

    // Widest word rotl1 can handle; callers pass their own WIDTH.
    localparam int MAX_W = 64;

    // Bits needed to hold a count running from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Counter widths for the default configuration.
    localparam int WARM_CNT_W_DEF = cnt_w(256);
    localparam int ACC_CNT_W_DEF  = cnt_w(8);
    localparam int REP_CNT_W_DEF  = cnt_w(4);

    // Rotate the low w bits of v left by one; bits at and above w return 0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 1; i < MAX_W; i++) begin
            if (i < w) r[i] = v[i-1];
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) r[0] = v[i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trng_osc_core.sv
// ============================================================================
// Module   : trng_osc_core
// Purpose  : Free-running XOR-loop oscillator lanes, one per raw sample bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trng_osc_core #(
    parameter int RAW_W = 32
) (
    output logic [RAW_W-1:0] lanes
);

`ifdef SYNTHESIS
    generate
        for (genvar g = 0; g < RAW_W; g++) begin : g_lane
            // Odd inversion count around the loop keeps it oscillating; keep
            // attributes stop synthesis from collapsing the loop.
            (* keep = "true", dont_touch = "true" *) logic [2:0] ring;
            assign ring[0]  = ring[2] ^ 1'b1;
            assign ring[1]  = ~ring[0];
            assign ring[2]  = ~ring[1];
            assign lanes[g] = ring[2];
        end
    endgenerate
`else
    assign lanes = 'x;
`endif

endmodule

`default_nettype wire

// File: rtl/trng_pool.sv
// ============================================================================
// Module   : trng_pool
// Purpose  : Oscillator capture, warm-up discard, rotate-XOR conditioning and
//            valid/ready output of random words. Optional repetition-count
//            health test enabled by defining TRNG_HEALTH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trng_pool
    import trng_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RAW_W      = 32,
    parameter int WARMUP_CYC = 256,
    parameter int ACC_CYC    = 8,
    parameter int REP_LIMIT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             test_mode,
    input  logic [RAW_W-1:0] test_raw,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             warm,
    output logic             health_fail
);

    localparam int WARM_W = cnt_w(WARMUP_CYC);
    localparam int CNT_W  = cnt_w(ACC_CYC);

    logic [RAW_W-1:0] lanes;
    logic [RAW_W-1:0] s1_data, s2_data;
    logic             s1_vld, s2_vld;

    trng_state_e       state, state_n;
    logic [WARM_W-1:0] warm_cnt, warm_cnt_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0]  acc, acc_n, acc_rot, acc_fold, raw_ext, data_n;
    logic              valid_n, warm_n, slot_free, rep_trip;

    trng_osc_core #(.RAW_W(RAW_W)) u_osc (.lanes(lanes));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
            s2_data <= '0;
            s2_vld  <= 1'b0;
        end else begin
            s1_data <= test_mode ? test_raw : lanes;
            s1_vld  <= en;
            s2_data <= s1_data;
            s2_vld  <= s1_vld;
        end
    end

    assign raw_ext  = WIDTH'(s2_data);
    assign acc_rot  = WIDTH'(rotl1(MAX_W'(acc), WIDTH));
    assign acc_fold = acc_rot ^ raw_ext;

`ifdef TRNG_HEALTH_EN
    localparam int REP_W = cnt_w(REP_LIMIT);

    logic [RAW_W-1:0] prev;
    logic             have_prev;
    logic [REP_W-1:0] rep, rep_n;

    // The first sample after reset has nothing to repeat.
    assign rep_n    = (have_prev && (s2_data == prev)) ? rep + 1'b1 : '0;
    assign rep_trip = s2_vld && (state != ST_FAULT) && (rep_n == REP_W'(REP_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            have_prev <= 1'b0;
            rep       <= '0;
        end else if (s2_vld && (state != ST_FAULT)) begin
            prev      <= s2_data;
            have_prev <= 1'b1;
            rep       <= rep_n;
        end
    end

    assign health_fail = (state == ST_FAULT);
`else
    assign rep_trip    = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        warm_cnt_n = warm_cnt;
        warm_n     = warm;
        acc_n      = acc;
        cnt_n      = cnt;
        data_n     = rnd_data;
        valid_n    = rnd_valid;
        slot_free  = !rnd_valid || rnd_ready;
        cnt_inc    = (cnt == CNT_W'(ACC_CYC)) ? cnt : cnt + 1'b1;

        if (rnd_valid && rnd_ready) valid_n = 1'b0;

        case (state)
            ST_WARMUP: begin
                if (s2_vld) begin
                    if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) begin
                        state_n = ST_COLLECT;
                        warm_n  = 1'b1;
                        acc_n   = '0;
                        cnt_n   = '0;
                    end else begin
                        warm_cnt_n = warm_cnt + 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (s2_vld) begin
                    acc_n = acc_fold;
                    cnt_n = cnt_inc;
                    // The accumulator keeps running across loads on purpose.
                    if ((cnt_inc == CNT_W'(ACC_CYC)) && slot_free) begin
                        data_n  = acc_fold;
                        valid_n = 1'b1;
                        cnt_n   = '0;
                    end
                end
            end
            default: valid_n = 1'b0;
        endcase

        // A tripping sample is neither counted nor folded.
        if (rep_trip) begin
            state_n    = ST_FAULT;
            valid_n    = 1'b0;
            warm_cnt_n = warm_cnt;
            warm_n     = warm;
            acc_n      = acc;
            cnt_n      = cnt;
            data_n     = rnd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_WARMUP;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt  <= '0;
            warm      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            warm_cnt  <= warm_cnt_n;
            warm      <= warm_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            rnd_data  <= data_n;
            rnd_valid <= valid_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trng_pool.sv
// ============================================================================
// Module   : tb_trng_pool
// Purpose  : Self-checking bench for trng_pool (WIDTH=8, RAW_W=8, WARMUP=4,
//            ACC=2, REP_LIMIT=3) driven through the test-injection path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trng_pool;

    localparam int WARM = 4;
    localparam int ACC  = 2;
    localparam int REP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       test_mode = 1'b1;
    logic [7:0] test_raw = 8'h00;
    logic       rnd_ready = 1'b0;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       warm;
    logic       health_fail;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic       m_pv [2];
    logic [7:0] m_pd [2];
    logic       m_valid, m_warm, m_fault;
    logic [7:0] m_data, m_acc;
    int         m_cnt, m_wcnt;
    logic [7:0] m_prev;
    logic       m_have;
    int         m_rep;

    trng_pool #(
        .WIDTH(8), .RAW_W(8), .WARMUP_CYC(WARM), .ACC_CYC(ACC), .REP_LIMIT(REP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .test_mode(test_mode), .test_raw(test_raw),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .warm(warm), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rotl(input logic [7:0] a);
        return ((a << 1) | (a >> 7)) & 8'hFF;
    endfunction

    task automatic model_reset();
        m_pv[0] = 0; m_pv[1] = 0; m_pd[0] = 0; m_pd[1] = 0;
        m_valid = 0; m_warm = 0; m_fault = 0; m_data = 0; m_acc = 0;
        m_cnt = 0; m_wcnt = 0; m_prev = 0; m_have = 0; m_rep = 0;
    endtask

    // Apply one clock of stimulus (called at a falling edge) and advance model.
    task automatic cyc(input logic e, input logic [7:0] d, input logic r);
        logic       pv, ov;
        logic [7:0] ps;
        en = e; test_raw = d; rnd_ready = r;
        pv = m_pv[1]; ps = m_pd[1];
        m_pv[1] = m_pv[0]; m_pd[1] = m_pd[0];
        m_pv[0] = e;       m_pd[0] = d;
        ov = m_valid;
        if (ov && r) m_valid = 0;
        if (pv && !m_fault) begin
`ifdef TRNG_HEALTH_EN
            m_rep  = (m_have && ps == m_prev) ? m_rep + 1 : 0;
            m_prev = ps;
            m_have = 1;
            if (m_rep == REP) m_fault = 1;
`endif
            if (!m_fault) begin
                if (!m_warm) begin
                    m_wcnt++;
                    if (m_wcnt == WARM) begin m_warm = 1; m_acc = 0; m_cnt = 0; end
                end else begin
                    m_acc = rotl(m_acc) ^ ps;
                    m_cnt = (m_cnt < ACC) ? m_cnt + 1 : ACC;
                    if (m_cnt == ACC && (!ov || r)) begin
                        m_data = m_acc; m_valid = 1; m_cnt = 0;
                    end
                end
            end
        end
        if (m_fault) m_valid = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; rnd_ready = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic drive_warmup();
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
        cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rnd_valid, rnd_data, warm, health_fail} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset: got v=%0b d=%02h w=%0b h=%0b, want all zero",
                     rnd_valid, rnd_data, warm, health_fail);
        end
    endtask

    task automatic test_warmup();
        logic [7:0] s [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, s[i], 0);
            n_cmp++;
            if ({rnd_valid, warm, health_fail} !== {1'b0, m_warm, m_fault}) begin
                n_bad++;
                $display("FAIL warmup c%0d: got v=%0b w=%0b h=%0b, want v=0 w=%0b h=%0b",
                         i, rnd_valid, warm, health_fail, m_warm, m_fault);
            end
        end
        n_cmp++;
        if (warm !== 1'b1) begin
            n_bad++;
            $display("FAIL warmup_done: got warm=%0b want 1", warm);
        end
    endtask

    task automatic test_basic();
        int         nv = 0;
        logic [7:0] seen = 8'h00;
        logic [7:0] s [5] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            cyc(i < 2, s[i], 1);
            if (rnd_valid === 1'b1) begin nv++; seen = rnd_data; end
            n_cmp++;
            if ({rnd_valid, rnd_data, warm, health_fail} !== {m_valid, m_data, m_warm, m_fault}) begin
                n_bad++;
                $display("FAIL basic c%0d: got v=%0b d=%02h w=%0b h=%0b, want v=%0b d=%02h w=%0b h=%0b",
                         i, rnd_valid, rnd_data, warm, health_fail, m_valid, m_data, m_warm, m_fault);
            end
        end
        n_cmp++;
        if (nv != 1 || seen !== 8'h12) begin
            n_bad++;
            $display("FAIL basic_word: got %0d valid cycles data=%02h, want 1 cycle data=12", nv, seen);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s [7] = '{8'h01, 8'h10, 8'h03, 8'h05, 8'h06, 8'h00, 8'h00};
        do_reset();
        drive_warmup();
        for (int i = 0; i < 7; i++) begin
            cyc(i < 5, s[i], 0);
            n_cmp++;
            if ({rnd_valid, rnd_data} !== {m_valid, m_data}) begin
                n_bad++;
                $display("FAIL bp_hold c%0d: got v=%0b d=%02h, want v=%0b d=%02h",
                         i, rnd_valid, rnd_data, m_valid, m_data);
            end
        end
        n_cmp++;
        if ({rnd_valid, rnd_data} !== {1'b1, 8'h12}) begin
            n_bad++;
            $display("FAIL bp_held: got v=%0b d=%02h, want v=1 d=12", rnd_valid, rnd_data);
        end
        // Ready rises exactly on the cycle the 0x00 sample is accepted.
        cyc(1, 8'h00, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        n_cmp++;
        if ({rnd_valid, rnd_data} !== {1'b1, rotl(8'h90)}) begin
            n_bad++;
            $display("FAIL bp_swap: got v=%0b d=%02h, want v=1 d=%02h", rnd_valid, rnd_data, rotl(8'h90));
        end
        cyc(0, 8'h00, 1);
        n_cmp++;
        if ({rnd_valid, rnd_data} !== {m_valid, m_data} || rnd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got v=%0b d=%02h, want v=0 d=%02h", rnd_valid, rnd_data, m_data);
        end
    endtask

    task automatic test_en_gating();
        logic [7:0] hd;
        logic       hv;
        do_reset();
        drive_warmup();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'($urandom), 0);
            n_cmp++;
            if ({rnd_valid, rnd_data} !== {m_valid, m_data}) begin
                n_bad++;
                $display("FAIL gate_pre c%0d: got v=%0b d=%02h, want v=%0b d=%02h",
                         i, rnd_valid, rnd_data, m_valid, m_data);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 8'($urandom), 0);
            if (i == 2) begin hd = rnd_data; hv = rnd_valid; end
            n_cmp++;
            if ({rnd_valid, rnd_data} !== {m_valid, m_data} || (i > 2 && {rnd_valid, rnd_data} !== {hv, hd})) begin
                n_bad++;
                $display("FAIL gate_gap c%0d: got v=%0b d=%02h, want v=%0b d=%02h",
                         i, rnd_valid, rnd_data, m_valid, m_data);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, 8'($urandom), i > 3);
            n_cmp++;
            if ({rnd_valid, rnd_data} !== {m_valid, m_data}) begin
                n_bad++;
                $display("FAIL gate_resume c%0d: got v=%0b d=%02h, want v=%0b d=%02h",
                         i, rnd_valid, rnd_data, m_valid, m_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_warmup();
        cyc(1, 8'h3C, 0); cyc(1, 8'hA5, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
        n_cmp++;
        if ({rnd_valid, rnd_data} !== {1'b1, m_data} || m_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: got v=%0b d=%02h, want v=1 d=%02h", rnd_valid, rnd_data, m_data);
        end
        do_reset();
        n_cmp++;
        if ({rnd_valid, warm} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstmid_clear: got v=%0b w=%0b, want v=0 w=0", rnd_valid, warm);
        end
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
        cyc(0, 8'h00, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
        n_cmp++;
        if (warm !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_3of4: got warm=%0b want 0", warm);
        end
        cyc(1, 8'h44, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
        n_cmp++;
        if (warm !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_4of4: got warm=%0b want 1", warm);
        end
    endtask

    task automatic test_health();
        do_reset();
        drive_warmup();
        for (int i = 0; i < 7; i++) begin
            cyc(i < 4, 8'h5A, 0);
            n_cmp++;
            if ({rnd_valid, rnd_data, health_fail} !== {m_valid, m_data, m_fault}) begin
                n_bad++;
                $display("FAIL health c%0d: got v=%0b d=%02h h=%0b, want v=%0b d=%02h h=%0b",
                         i, rnd_valid, rnd_data, health_fail, m_valid, m_data, m_fault);
            end
        end
`ifdef TRNG_HEALTH_EN
        n_cmp++;
        if ({health_fail, rnd_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL health_trip: got h=%0b v=%0b, want h=1 v=0", health_fail, rnd_valid);
        end
`else
        n_cmp++;
        if ({health_fail, rnd_valid, rnd_data} !== {1'b0, 1'b1, 8'h5A ^ rotl(8'h5A)}) begin
            n_bad++;
            $display("FAIL health_off: got h=%0b v=%0b d=%02h, want h=0 v=1 d=%02h",
                     health_fail, rnd_valid, rnd_data, 8'h5A ^ rotl(8'h5A));
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(1, 0) == 1);
            n_cmp++;
            if ({rnd_valid, rnd_data, warm, health_fail} !== {m_valid, m_data, m_warm, m_fault}) begin
                n_bad++;
                $display("FAIL random c%0d: got v=%0b d=%02h w=%0b h=%0b, want v=%0b d=%02h w=%0b h=%0b",
                         i, rnd_valid, rnd_data, warm, health_fail, m_valid, m_data, m_warm, m_fault);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_warmup();
        test_basic();
        test_backpressure();
        test_en_gating();
        test_reset_mid();
        test_health();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
